// File: rtl/ex_unit.sv
// ex_unit: execute stage ALU with optional radix-2 iterative divider (enabled by EX_DIV_EN); 1-cycle latency, divides 34 edges.
// Backpressure: o_stallReq holds upstream and ex_* stable while dividing; mem_* carry bubbles meanwhile.
module ex_unit #(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUSEL_W   = 3,
    parameter int ALUOP_W    = 5,
    parameter int MEMOP_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     ex_inst,
    input  logic [ALUSEL_W-1:0]   ex_alusel,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [WORD_W-1:0]     ex_srcLeft,
    input  logic [WORD_W-1:0]     ex_srcRight,
    input  logic [MEMOP_W-1:0]    ex_memop,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_writeEnable,
    input  logic                  ex_flush,
    output logic                  o_stallReq,
    output logic [WORD_W-1:0]     mem_inst,
    output logic [WORD_W-1:0]     mem_result,
    output logic [MEMOP_W-1:0]    mem_memop,
    output logic [REG_ADDR_W-1:0] mem_dest,
    output logic                  mem_writeEnable
);
    localparam int SHAMT_W = $clog2(WORD_W);

    localparam logic [ALUSEL_W-1:0] SEL_NOP     = ALUSEL_W'(0);
    localparam logic [ALUSEL_W-1:0] SEL_LOGIC   = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] SEL_ARITH   = ALUSEL_W'(2);
    localparam logic [ALUSEL_W-1:0] SEL_MEMACC  = ALUSEL_W'(3);
    localparam logic [ALUSEL_W-1:0] SEL_SPECIAL = ALUSEL_W'(4);

    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] OP_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_REM  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] OP_REMU = ALUOP_W'(7);

    localparam logic [MEMOP_W-1:0] MEM_OP_NOP = '0;

    logic [SHAMT_W-1:0] shamt;
    logic               is_div;
    logic [WORD_W-1:0]  alu_res;
    logic               div_stall;
    logic               div_done;
    logic [WORD_W-1:0]  div_res;

    logic [WORD_W-1:0]     mem_inst_d,   mem_inst_q;
    logic [WORD_W-1:0]     mem_result_d, mem_result_q;
    logic [MEMOP_W-1:0]    mem_memop_d,  mem_memop_q;
    logic [REG_ADDR_W-1:0] mem_dest_d,   mem_dest_q;
    logic                  mem_we_d,     mem_we_q;

    assign shamt  = ex_srcRight[SHAMT_W-1:0];
    assign is_div = (ex_alusel == SEL_ARITH) &&
                    (ex_aluop == OP_DIV || ex_aluop == OP_DIVU ||
                     ex_aluop == OP_REM || ex_aluop == OP_REMU);

    always_comb begin
        alu_res = '0;
        case (ex_alusel)
            SEL_LOGIC: begin
                case (ex_aluop)
                    OP_AND:  alu_res = ex_srcLeft & ex_srcRight;
                    OP_OR:   alu_res = ex_srcLeft | ex_srcRight;
                    OP_XOR:  alu_res = ex_srcLeft ^ ex_srcRight;
                    OP_NOR:  alu_res = ~(ex_srcLeft | ex_srcRight);
                    OP_SLL:  alu_res = ex_srcLeft << shamt;
                    OP_SRL:  alu_res = ex_srcLeft >> shamt;
                    OP_SRA:  alu_res = $unsigned($signed(ex_srcLeft) >>> shamt);
                    default: alu_res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (ex_aluop)
                    OP_ADD:  alu_res = ex_srcLeft + ex_srcRight;
                    OP_SUB:  alu_res = ex_srcLeft - ex_srcRight;
                    OP_SLT:  alu_res = {{(WORD_W-1){1'b0}}, $signed(ex_srcLeft) < $signed(ex_srcRight)};
                    OP_SLTU: alu_res = {{(WORD_W-1){1'b0}}, ex_srcLeft < ex_srcRight};
                    default: alu_res = '0;
                endcase
            end
            SEL_MEMACC:           alu_res = ex_srcLeft + ex_srcRight;
            SEL_SPECIAL, SEL_NOP: alu_res = '0;
            default:              alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [WORD_W-1:0] quo_d, quo_q;
    logic [WORD_W-1:0] rem_d, rem_q;
    logic [WORD_W-1:0] dvs_d, dvs_q;
    logic              neg_quo_d, neg_quo_q;
    logic              neg_rem_d, neg_rem_q;
    logic              is_rem_d, is_rem_q;
    logic              a_neg, b_neg;
    logic [WORD_W:0]   trial;
    logic [WORD_W-1:0] quo_fix, rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        div_stall = 1'b0;
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        trial     = {rem_q, quo_q[WORD_W-1]} - {1'b0, dvs_q};
        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    div_stall = 1'b1;
                    a_neg     = (ex_aluop == OP_DIV || ex_aluop == OP_REM) && ex_srcLeft[WORD_W-1];
                    b_neg     = (ex_aluop == OP_DIV || ex_aluop == OP_REM) && ex_srcRight[WORD_W-1];
                    quo_d     = a_neg ? -ex_srcLeft : ex_srcLeft;
                    dvs_d     = b_neg ? -ex_srcRight : ex_srcRight;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    is_rem_d  = (ex_aluop == OP_REM || ex_aluop == OP_REMU);
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                div_stall = 1'b1;
                // quo_q shifts the dividend out at the top while quotient bits enter at the bottom
                if (!trial[WORD_W]) begin
                    rem_d = trial[WORD_W-1:0];
                    quo_d = {quo_q[WORD_W-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WORD_W-2:0], quo_q[WORD_W-1]};
                    quo_d = {quo_q[WORD_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WORD_W-1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (ex_flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
        end
    end

    // a zero divisor yields all-ones quotient regardless of operand signs
    assign quo_fix  = (dvs_q == '0) ? '1 : (neg_quo_q ? -quo_q : quo_q);
    assign rem_fix  = neg_rem_q ? -rem_q : rem_q;
    assign div_res  = is_rem_q ? rem_fix : quo_fix;
    assign div_done = (state_q == S_DONE);
`else
    assign div_stall = 1'b0;
    assign div_done  = 1'b0;
    assign div_res   = '0;
`endif

    assign o_stallReq = div_stall & ~ex_flush;

    always_comb begin
        mem_inst_d   = ex_inst;
        mem_result_d = alu_res;
        mem_memop_d  = ex_memop;
        mem_dest_d   = ex_dest;
        mem_we_d     = ex_writeEnable & ~is_div;
        if (div_done) begin
            mem_result_d = div_res;
            mem_we_d     = ex_writeEnable;
        end
        if (ex_flush || div_stall) begin
            mem_inst_d   = '0;
            mem_result_d = '0;
            mem_memop_d  = MEM_OP_NOP;
            mem_dest_d   = '0;
            mem_we_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_inst_q   <= '0;
            mem_result_q <= '0;
            mem_memop_q  <= MEM_OP_NOP;
            mem_dest_q   <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            mem_inst_q   <= mem_inst_d;
            mem_result_q <= mem_result_d;
            mem_memop_q  <= mem_memop_d;
            mem_dest_q   <= mem_dest_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign mem_inst        = mem_inst_q;
    assign mem_result      = mem_result_q;
    assign mem_memop       = mem_memop_q;
    assign mem_dest        = mem_dest_q;
    assign mem_writeEnable = mem_we_q;
endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit: ALU ops, divider timing/results, flush and reset behaviour.
module tb_ex_unit;
    localparam logic [2:0] SEL_NOP = 3'd0, SEL_LOGIC = 3'd1, SEL_ARITH = 3'd2,
                           SEL_MEMACC = 3'd3, SEL_SPECIAL = 3'd4;
    localparam logic [4:0] OP_AND = 5'd0, OP_OR = 5'd1, OP_XOR = 5'd2, OP_NOR = 5'd3,
                           OP_SLL = 5'd4, OP_SRL = 5'd5, OP_SRA = 5'd6;
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLT = 5'd2, OP_SLTU = 5'd3,
                           OP_DIV = 5'd4, OP_DIVU = 5'd5, OP_REM = 5'd6, OP_REMU = 5'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_inst;
    logic [2:0]  ex_alusel;
    logic [4:0]  ex_aluop;
    logic [31:0] ex_srcLeft;
    logic [31:0] ex_srcRight;
    logic [1:0]  ex_memop;
    logic [4:0]  ex_dest;
    logic        ex_writeEnable;
    logic        ex_flush;
    logic        o_stallReq;
    logic [31:0] mem_inst;
    logic [31:0] mem_result;
    logic [1:0]  mem_memop;
    logic [4:0]  mem_dest;
    logic        mem_writeEnable;

    int tests = 0;
    int fails = 0;

    ex_unit dut (
        .clk(clk), .rst(rst), .ex_inst(ex_inst), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
        .ex_srcLeft(ex_srcLeft), .ex_srcRight(ex_srcRight), .ex_memop(ex_memop),
        .ex_dest(ex_dest), .ex_writeEnable(ex_writeEnable), .ex_flush(ex_flush),
        .o_stallReq(o_stallReq), .mem_inst(mem_inst), .mem_result(mem_result),
        .mem_memop(mem_memop), .mem_dest(mem_dest), .mem_writeEnable(mem_writeEnable)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] memop, input logic [4:0] dest,
                         input logic we);
        ex_alusel      = sel;
        ex_aluop       = op;
        ex_srcLeft     = a;
        ex_srcRight    = b;
        ex_memop       = memop;
        ex_dest        = dest;
        ex_writeEnable = we;
        ex_inst        = {a[15:0], b[15:0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag, input logic [2:0] sel, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        drive(sel, op, a, b, 2'd0, 5'd1, 1'b1);
        tick();
        check(tag, mem_result, exp);
    endtask

`ifdef EX_DIV_EN
    task automatic run_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int n;
        int bad;
        drive(SEL_ARITH, op, a, b, 2'd0, 5'd5, 1'b1);
        #1;
        check({tag, "_stall_start"}, 32'(o_stallReq), 32'd1);
        n   = 0;
        bad = 0;
        while (o_stallReq && n < 40) begin
            tick();
            n++;
            if (mem_writeEnable !== 1'b0 || mem_result !== 32'd0 || mem_dest !== 5'd0) bad++;
        end
        check({tag, "_stall_cycles"}, 32'(n), 32'd33);
        check({tag, "_bubbles"}, 32'(bad), 32'd0);
        tick();
        check({tag, "_result"}, mem_result, exp);
        check({tag, "_we"}, 32'(mem_writeEnable), 32'd1);
        drive(SEL_NOP, OP_ADD, 32'd0, 32'd0, 2'd0, 5'd0, 1'b0);
        tick();
        check({tag, "_once"}, 32'(mem_writeEnable), 32'd0);
    endtask
`endif

    initial begin
        rst      = 1'b1;
        ex_flush = 1'b0;
        drive(SEL_ARITH, OP_ADD, 32'd5, 32'd6, 2'd1, 5'd7, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", mem_result, 32'd0);
        check("rst_we", 32'(mem_writeEnable), 32'd0);
        check("rst_memop", 32'(mem_memop), 32'd0);
        check("rst_dest", 32'(mem_dest), 32'd0);
        check("rst_inst", mem_inst, 32'd0);
        check("rst_stall", 32'(o_stallReq), 32'd0);
        rst = 1'b0;

        drive(SEL_ARITH, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 5'd3, 1'b1);
        #1;
        check("add_stall", 32'(o_stallReq), 32'd0);
        tick();
        check("add_result", mem_result, 32'd0);
        check("add_dest", 32'(mem_dest), 32'd3);
        check("add_we", 32'(mem_writeEnable), 32'd1);
        check("add_inst", mem_inst, 32'hFFFF_0001);

        alu("slt",  SEL_ARITH,  OP_SLT,  32'h8000_0000, 32'd1, 32'd1);
        alu("sltu", SEL_ARITH,  OP_SLTU, 32'h8000_0000, 32'd1, 32'd0);
        alu("sra",  SEL_LOGIC,  OP_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000);
        alu("srl",  SEL_LOGIC,  OP_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000);
        alu("sll",  SEL_LOGIC,  OP_SLL,  32'd1, 32'h0000_003F, 32'h8000_0000);
        alu("sub",  SEL_ARITH,  OP_SUB,  32'd5, 32'd7, 32'hFFFF_FFFE);
        alu("and",  SEL_LOGIC,  OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu("or",   SEL_LOGIC,  OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0);
        alu("xor",  SEL_LOGIC,  OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        alu("nor",  SEL_LOGIC,  OP_NOR,  32'h0F0F_0F0F, 32'hF0F0_0000, 32'h0000_F0F0);
        alu("spec", SEL_SPECIAL, OP_ADD, 32'd5, 32'd6, 32'd0);

        drive(SEL_MEMACC, OP_ADD, 32'hFFFF_FFF0, 32'h0000_0020, 2'd2, 5'd9, 1'b0);
        tick();
        check("memacc_addr", mem_result, 32'h0000_0010);
        check("memacc_memop", 32'(mem_memop), 32'd2);
        check("memacc_we", 32'(mem_writeEnable), 32'd0);

`ifdef EX_DIV_EN
        run_div("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("divu_by0",  OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_div("remu_by0",  OP_REMU, 32'd100, 32'd0, 32'd100);
        run_div("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);

        drive(SEL_ARITH, OP_DIV, 32'd1000, 32'd3, 2'd0, 5'd4, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("flush_pre_stall", 32'(o_stallReq), 32'd1);
        ex_flush = 1'b1;
        #1;
        check("flush_stall_drop", 32'(o_stallReq), 32'd0);
        tick();
        check("flush_we", 32'(mem_writeEnable), 32'd0);
        check("flush_result", mem_result, 32'd0);
        ex_flush = 1'b0;
        drive(SEL_ARITH, OP_ADD, 32'd2, 32'd3, 2'd0, 5'd6, 1'b1);
        #1;
        check("post_flush_stall", 32'(o_stallReq), 32'd0);
        tick();
        check("post_flush_add", mem_result, 32'd5);
        check("post_flush_we", 32'(mem_writeEnable), 32'd1);

        drive(SEL_ARITH, OP_DIVU, 32'd1000, 32'd3, 2'd0, 5'd4, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("midrst_result", mem_result, 32'd0);
        check("midrst_we", 32'(mem_writeEnable), 32'd0);
        check("midrst_dest", 32'(mem_dest), 32'd0);
        drive(SEL_NOP, OP_ADD, 32'd0, 32'd0, 2'd0, 5'd0, 1'b0);
        #1;
        check("midrst_stall", 32'(o_stallReq), 32'd0);
        rst = 1'b0;
        run_div("div_after_rst", OP_DIVU, 32'd1000, 32'd3, 32'd333);
`else
        drive(SEL_ARITH, OP_DIV, 32'hFFFF_FFF9, 32'd2, 2'd0, 5'd5, 1'b1);
        #1;
        check("nodiv_stall", 32'(o_stallReq), 32'd0);
        tick();
        check("nodiv_we", 32'(mem_writeEnable), 32'd0);
        check("nodiv_result", mem_result, 32'd0);
        drive(SEL_ARITH, OP_REMU, 32'd100, 32'd7, 2'd0, 5'd5, 1'b1);
        #1;
        check("nodiv_remu_stall", 32'(o_stallReq), 32'd0);
        tick();
        check("nodiv_remu_we", 32'(mem_writeEnable), 32'd0);
        check("nodiv_remu_result", mem_result, 32'd0);
`endif

        ex_flush = 1'b1;
        drive(SEL_ARITH, OP_ADD, 32'd8, 32'd9, 2'd1, 5'd2, 1'b1);
        tick();
        check("flush_add_we", 32'(mem_writeEnable), 32'd0);
        check("flush_add_memop", 32'(mem_memop), 32'd0);
        ex_flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
